// File: rtl/io_input_ctrl.sv
// io_input_ctrl: synchronized input channels with a register read port; define IO_INPUT_DEBOUNCE_EN for per-channel debounce.
module io_input_ctrl #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(6'b110000),
  parameter int DB_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        sel_addr,
  input  logic                     rd_en,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     addr_err
);
  if (int'(BASE_ADDR) + NUM_CH > (1 << ADDR_W) - 1 || NUM_CH < 1 || NUM_CH > 16 || NUM_CH > DATA_W || DB_CYCLES < 1) begin : g_param_err
    $error("io_input_ctrl: illegal parameter combination");
  end
  logic [NUM_CH*DATA_W-1:0] sync1, sync2, stable;
  logic [NUM_CH-1:0] flag, diff, upd, clr;
  logic [ADDR_W-1:0] off;
  logic [DATA_W-1:0] rd_mux, status;
  logic mapped;
  always_comb begin
    off = sel_addr - BASE_ADDR;
    mapped = off <= ADDR_W'(NUM_CH);
    status = '0;
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      status[i] = flag[i];
      diff[i] = sync2[i*DATA_W +: DATA_W] != stable[i*DATA_W +: DATA_W];
      clr[i] = rd_en && off == ADDR_W'(i);
      rd_mux = off == ADDR_W'(i) ? stable[i*DATA_W +: DATA_W] : rd_mux;
    end
    rd_mux = off == ADDR_W'(NUM_CH) ? status : rd_mux;
  end
`ifdef IO_INPUT_DEBOUNCE_EN
  localparam int CW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
  logic [CW-1:0] cnt [NUM_CH];
  always_comb
    for (int i = 0; i < NUM_CH; i++)
      upd[i] = diff[i] && cnt[i] == CW'(DB_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    else
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= (!diff[i] || upd[i]) ? '0 : cnt[i] + 1'b1;
`else
  assign upd = diff;
`endif
  // A load that changes stable sets the flag even when a read clears it the same edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      stable <= '0;
      flag <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      sync1 <= in_data;
      sync2 <= sync1;
      rd_valid <= rd_en;
      addr_err <= rd_en && !mapped;
      if (rd_en) rd_data <= rd_mux;
      for (int i = 0; i < NUM_CH; i++) begin
        if (upd[i]) stable[i*DATA_W +: DATA_W] <= sync2[i*DATA_W +: DATA_W];
        flag[i] <= upd[i] | (flag[i] & ~clr[i]);
      end
    end
endmodule

// File: tb/tb_io_input_ctrl.sv
// tb_io_input_ctrl: random and directed reads checked against a cycle-level behavioural model.
module tb_io_input_ctrl;
  localparam int NUM_CH = 3;
  localparam int DATA_W = 32;
  localparam logic [5:0] BASE = 6'b110000;
`ifdef IO_INPUT_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 1;
`endif
  logic clk = 0, rst_n = 0, rd_en = 0;
  logic [5:0] sel_addr = '0;
  logic [NUM_CH*DATA_W-1:0] in_data = '0;
  logic [DATA_W-1:0] rd_data;
  logic rd_valid, addr_err;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  io_input_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(6), .BASE_ADDR(BASE), .DB_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sel_addr(sel_addr), .rd_en(rd_en), .in_data(in_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .addr_err(addr_err)
  );
  logic [DATA_W-1:0] m_stable [NUM_CH];
  logic m_flag [NUM_CH];
  int m_run [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] m_pipe [$];
  logic [DATA_W-1:0] e_data;
  logic e_valid, e_err;
  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_pipe = '{'0, '0};
    for (int i = 0; i < NUM_CH; i++) begin
      m_stable[i] = '0;
      m_flag[i] = 1'b0;
      m_run[i] = 0;
    end
    e_data = '0;
    e_valid = 1'b0;
    e_err = 1'b0;
  endtask
  // Inputs reach the stable stage two edges after capture; debounce demands DB differing edges in a row.
  task automatic model_step();
    logic [NUM_CH*DATA_W-1:0] cand;
    int a, base, clear;
    cand = m_pipe.pop_front();
    m_pipe.push_back(in_data);
    a = int'(sel_addr);
    base = int'(BASE);
    clear = -1;
    e_valid = rd_en;
    e_err = 1'b0;
    if (rd_en) begin
      if (a >= base && a < base + NUM_CH) begin
        e_data = m_stable[a - base];
        clear = a - base;
      end else if (a == base + NUM_CH) begin
        e_data = '0;
        for (int i = 0; i < NUM_CH; i++) e_data[i] = m_flag[i];
      end else begin
        e_data = '0;
        e_err = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      logic set;
      set = 1'b0;
      if (cand[i*DATA_W +: DATA_W] != m_stable[i]) begin
        if (m_run[i] == DB - 1) begin
          m_stable[i] = cand[i*DATA_W +: DATA_W];
          m_run[i] = 0;
          set = 1'b1;
        end else m_run[i]++;
      end else m_run[i] = 0;
      if (i == clear) m_flag[i] = 1'b0;
      if (set) m_flag[i] = 1'b1;
    end
  endtask
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end
  initial forever begin
    @(negedge clk);
    check("model_valid", {31'b0, rd_valid}, {31'b0, e_valid});
    check("model_err", {31'b0, addr_err}, {31'b0, e_err});
    check("model_data", rd_data, e_data);
  end
  task automatic do_read(input logic [5:0] addr, input logic [DATA_W-1:0] exp, input logic err, input string name);
    sel_addr = addr;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check(name, rd_data, exp);
    check({name, "_valid"}, {31'b0, rd_valid}, 32'd1);
    check({name, "_err"}, {31'b0, addr_err}, {31'b0, err});
  endtask
  initial begin
    logic [DATA_W-1:0] exp_status;
    repeat (3) @(negedge clk);
    check("reset_data", rd_data, 32'h0);
    check("reset_valid", {31'b0, rd_valid}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(BASE + 6'd1, 32'h0, 1'b0, "ch1_zero");
    in_data[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
    repeat (DB + 6) @(negedge clk);
    do_read(BASE + 6'd3, 32'h4, 1'b0, "status_ch2");
    do_read(BASE + 6'd2, 32'hDEADBEEF, 1'b0, "ch2_data");
    do_read(BASE + 6'd3, 32'h0, 1'b0, "status_cleared");
    do_read(6'b111111, 32'h0, 1'b1, "unmapped");
    @(negedge clk);
    check("unmapped_err_drop", {31'b0, addr_err}, 32'h0);
    check("unmapped_valid_drop", {31'b0, rd_valid}, 32'h0);
    in_data[0 +: DATA_W] = 32'h5;
    repeat (DB + 1) @(negedge clk);
    do_read(BASE, 32'h0, 1'b0, "ch0_race_old");
    do_read(BASE + 6'd3, 32'h1, 1'b0, "status_race");
    do_read(BASE, 32'h5, 1'b0, "ch0_new");
`ifdef IO_INPUT_DEBOUNCE_EN
    in_data[DATA_W +: DATA_W] = 32'h1;
    repeat (3) @(negedge clk);
    in_data[DATA_W +: DATA_W] = 32'h0;
    repeat (10) @(negedge clk);
    do_read(BASE + 6'd1, 32'h0, 1'b0, "glitch_ch1");
    do_read(BASE + 6'd3, 32'h0, 1'b0, "glitch_status");
    in_data[DATA_W +: DATA_W] = 32'h1;
    repeat (10) @(negedge clk);
    do_read(BASE + 6'd3, 32'h2, 1'b0, "held_status");
    do_read(BASE + 6'd1, 32'h1, 1'b0, "held_ch1");
`endif
    sel_addr = BASE;
    rd_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    check("rst_abort_valid", {31'b0, rd_valid}, 32'h0);
    check("rst_abort_data", rd_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_exit_valid", {31'b0, rd_valid}, 32'h0);
    check("rst_exit_err", {31'b0, addr_err}, 32'h0);
    repeat (DB + 6) @(negedge clk);
    exp_status = 32'h5 | (in_data[DATA_W +: DATA_W] != 0 ? 32'h2 : 32'h0);
    do_read(BASE + 6'd3, exp_status, 1'b0, "rst_exit_status");
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        int c;
        c = int'($urandom_range(0, NUM_CH - 1));
        in_data[c*DATA_W +: DATA_W] = $urandom_range(0, 3) == 0 ? 32'h0 : DATA_W'($urandom());
      end
      sel_addr = $urandom_range(0, 7) == 0 ? 6'($urandom()) : 6'(BASE + 6'($urandom_range(0, NUM_CH)));
      rd_en = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
